fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer between the next-PC redirect sources and instruction memory.
- Owns the architectural PC and issues word requests to imem over a req/ack handshake.
- Buffers one returned word in a skid register and presents fetched instructions to the IF/ID boundary.
- Arbitrates redirects from exception, eret and ID-stage branch/jump resolution, and discards stale in-flight fetches.

---
 rtl/fetch_ctrl_if.sv | 22 ++
 rtl/fetch_ctrl.sv | 135 +++++++++++++
 tb/tb_fetch_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch sequencer and imem.
// imem_req/imem_addr are held until imem_ack; imem_rdata is meaningful only with imem_ack.
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues imem word requests, buffers one
// returned word in a skid register and arbitrates exc/eret/branch redirects.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall_i,
  input  logic         br_valid,
  input  logic [31:0]  br_target,
  input  logic         exc_req,
  input  logic         eret_req,
  input  logic [31:0]  epc,
  fetch_ctrl_if.master imem,
  output logic         if_valid,
  output logic [31:0]  if_instr,
  output logic [31:0]  if_pc,
  output logic         flush_o,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    KILL = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] kill_addr, kill_addr_nxt;
  logic [31:0] skid_instr, skid_instr_nxt;
  logic [31:0] skid_pc, skid_pc_nxt;
  logic        if_valid_nxt;
  logic [31:0] if_instr_nxt, if_pc_nxt;
  logic        flush_nxt;
  logic        redirect;
  logic        slot_free;
  logic [31:0] raw_target, target;

  // A branch stalled in ID is not yet resolved, so only exc/eret bypass the stall.
  always_comb begin
    redirect = exc_req | eret_req | (br_valid & ~stall_i);
    if (exc_req)       raw_target = EXC_VEC;
    else if (eret_req) raw_target = epc;
    else               raw_target = br_target;
    target    = {raw_target[31:2], 2'b00};
    slot_free = ~if_valid | ~stall_i;
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    kill_addr_nxt  = kill_addr;
    skid_instr_nxt = skid_instr;
    skid_pc_nxt    = skid_pc;
    if_valid_nxt   = if_valid & stall_i;
    if_instr_nxt   = if_instr;
    if_pc_nxt      = if_pc;
    flush_nxt      = exc_req | eret_req;

    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        kill_addr_nxt = pc;
        if (imem.imem_ack) begin
          pc_nxt = pc + 32'd4;
          if (slot_free) begin
            if_valid_nxt = 1'b1;
            if_instr_nxt = imem.imem_rdata;
            if_pc_nxt    = pc;
          end else begin
            skid_instr_nxt = imem.imem_rdata;
            skid_pc_nxt    = pc;
            state_nxt      = HOLD;
          end
        end
      end
      HOLD: begin
        if (slot_free) begin
          if_valid_nxt = 1'b1;
          if_instr_nxt = skid_instr;
          if_pc_nxt    = skid_pc;
          state_nxt    = REQ;
        end
      end
      KILL: begin
        if (imem.imem_ack) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase

    // Redirect overrides everything above; an unacked request is retired via KILL.
    if (redirect) begin
      pc_nxt       = target;
      if_valid_nxt = 1'b0;
      case (state)
        REQ:     state_nxt = imem.imem_ack ? REQ : KILL;
        KILL:    state_nxt = imem.imem_ack ? REQ : KILL;
        default: state_nxt = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      kill_addr  <= 32'd0;
      skid_instr <= 32'd0;
      skid_pc    <= 32'd0;
      if_valid   <= 1'b0;
      if_instr   <= 32'd0;
      if_pc      <= 32'd0;
      flush_o    <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      kill_addr  <= kill_addr_nxt;
      skid_instr <= skid_instr_nxt;
      skid_pc    <= skid_pc_nxt;
      if_valid   <= if_valid_nxt;
      if_instr   <= if_instr_nxt;
      if_pc      <= if_pc_nxt;
      flush_o    <= flush_nxt;
    end
  end

  // KILL keeps presenting the stale address until its ack retires it.
  assign imem.imem_req  = (state == REQ) || (state == KILL);
  assign imem.imem_addr = (state == KILL) ? kill_addr : {pc[31:2], 2'b00};
  assign dbg_state      = state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by randomized traffic, checked
// against a program-order model of the instruction stream and the bus/stall rules.
module tb_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC  = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_i = 1'b0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        exc_req = 1'b0;
  logic        eret_req = 1'b0;
  logic [31:0] epc = 32'd0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush_o;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int consumed = 0;
  logic [31:0] exp_q[$];

  fetch_ctrl_if bus();

  fetch_ctrl #(.RESET_PC(RESET_PC), .EXC_VEC(EXC_VEC)) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i),
    .br_valid(br_valid), .br_target(br_target),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .imem(bus.master),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .flush_o(flush_o), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Memory contents: odd multiplier makes every address map to a distinct word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 2))
      0:       return $urandom();
      1:       return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      default: return RESET_PC + 32'($urandom_range(0, 255));
    endcase
  endfunction

  // One clock: sample pre-edge inputs/outputs, then check post-edge state at negedge.
  task automatic cycle();
    logic        p_valid, p_stall, p_req, p_ack, p_exc, p_eret, p_br;
    logic [31:0] p_pc, p_instr, p_addr, p_btgt, p_epc, tgt, e;
    p_valid = if_valid;  p_stall = stall_i;  p_req = bus.imem_req;
    p_ack   = bus.imem_ack; p_exc = exc_req; p_eret = eret_req; p_br = br_valid;
    p_pc    = if_pc;     p_instr = if_instr; p_addr = bus.imem_addr;
    p_btgt  = br_target; p_epc = epc;
    @(posedge clk);
    @(negedge clk);
    if (p_exc || p_eret || (p_br && !p_stall)) begin
      tgt = p_exc ? EXC_VEC : (p_eret ? p_epc : p_btgt);
      tgt[1:0] = 2'b00;
      exp_q.delete();
      exp_q.push_back(tgt);
    end else if (p_valid && !p_stall) begin
      e = exp_q.pop_front();
      chk32("stream_pc", p_pc, e);
      chk32("stream_instr", p_instr, mem_word(e));
      exp_q.push_back(e + 32'd4);
      consumed++;
    end
    chk1("flush_pulse", flush_o, p_exc | p_eret);
    if (p_valid && p_stall && !(p_exc || p_eret)) begin
      chk1("stall_hold_valid", if_valid, 1'b1);
      chk32("stall_hold_pc", if_pc, p_pc);
      chk32("stall_hold_instr", if_instr, p_instr);
    end
    if (p_req && !p_ack) begin
      chk1("req_held", bus.imem_req, 1'b1);
      chk32("addr_held", bus.imem_addr, p_addr);
    end
    chk32("addr_align", {30'd0, bus.imem_addr[1:0]}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0; stall_i = 1'b0; br_valid = 1'b0; exc_req = 1'b0; eret_req = 1'b0;
    bus.imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk1("rst_req", bus.imem_req, 1'b0);
    chk1("rst_valid", if_valid, 1'b0);
    chk32("rst_if_pc", if_pc, 32'd0);
    chk32("rst_if_instr", if_instr, 32'd0);
    chk1("rst_flush", flush_o, 1'b0);
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    reset = 1'b1;
  endtask

  initial begin
    int c0;
    bus.imem_ack = 1'b0;
    #1 reset = 1'b0;

    // Streaming at one word per cycle with a zero-wait memory
    do_reset();
    bus.imem_ack = 1'b1;
    cycle();
    chk1("t1_req", bus.imem_req, 1'b1);
    chk32("t1_addr0", bus.imem_addr, RESET_PC);
    chk1("t1_valid0", if_valid, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      chk32("t1_addr", bus.imem_addr, RESET_PC + 32'(4 * i));
      chk32("t1_if_pc", if_pc, RESET_PC + 32'(4 * (i - 1)));
      chk1("t1_valid", if_valid, 1'b1);
    end

    // Stall with full slot: word goes to skid, request drops, resumes in order
    stall_i = 1'b1; bus.imem_ack = 1'b1;
    cycle();
    chk32("t2_if_pc", if_pc, 32'h3008);
    chk1("t2_req_hold", bus.imem_req, 1'b0);
    bus.imem_ack = 1'b0;
    repeat (2) begin
      cycle();
      chk32("t2_if_pc_st", if_pc, 32'h3008);
      chk1("t2_req_st", bus.imem_req, 1'b0);
    end
    stall_i = 1'b0;
    cycle();
    chk32("t2_skid_pc", if_pc, 32'h300C);
    chk32("t2_skid_instr", if_instr, mem_word(32'h300C));
    chk1("t2_req_resume", bus.imem_req, 1'b1);
    chk32("t2_addr_resume", bus.imem_addr, 32'h3010);
    bus.imem_ack = 1'b1;
    cycle();
    chk32("t2_next_pc", if_pc, 32'h3010);
    chk32("t2_next_addr", bus.imem_addr, 32'h3014);

    // Branch during a slow fetch: stale address held until ack, then discarded
    do_reset();
    bus.imem_ack = 1'b1;
    repeat (3) cycle();
    chk32("t3_addr", bus.imem_addr, 32'h3008);
    bus.imem_ack = 1'b0; br_valid = 1'b1; br_target = 32'h3100;
    cycle();
    br_valid = 1'b0;
    chk32("t3_stale_addr", bus.imem_addr, 32'h3008);
    chk1("t3_stale_req", bus.imem_req, 1'b1);
    chk1("t3_killed_valid", if_valid, 1'b0);
    repeat (2) begin
      cycle();
      chk32("t3_stale_wait", bus.imem_addr, 32'h3008);
      chk1("t3_wait_valid", if_valid, 1'b0);
    end
    bus.imem_ack = 1'b1;
    cycle();
    chk32("t3_new_addr", bus.imem_addr, 32'h3100);
    chk1("t3_discard", if_valid, 1'b0);
    cycle();
    chk32("t3_if_pc", if_pc, 32'h3100);
    chk1("t3_valid", if_valid, 1'b1);

    // Simultaneous exc/eret/branch: exception wins
    exc_req = 1'b1; eret_req = 1'b1; epc = 32'h3040; br_valid = 1'b1; br_target = 32'h3200;
    cycle();
    exc_req = 1'b0; eret_req = 1'b0; br_valid = 1'b0;
    chk1("t4_valid", if_valid, 1'b0);
    chk1("t4_flush", flush_o, 1'b1);
    chk32("t4_addr", bus.imem_addr, EXC_VEC);
    cycle();
    chk1("t4_flush_end", flush_o, 1'b0);
    chk32("t4_if_pc", if_pc, EXC_VEC);
    chk32("t4_addr_next", bus.imem_addr, EXC_VEC + 32'd4);

    // Branch ignored under stall; branch with simultaneous ack discards the word
    stall_i = 1'b1; br_valid = 1'b1; br_target = 32'h5000; bus.imem_ack = 1'b0;
    cycle();
    chk32("t5_ign_addr", bus.imem_addr, 32'h4184);
    chk32("t5_ign_pc", if_pc, EXC_VEC);
    stall_i = 1'b0; br_target = 32'h5003; bus.imem_ack = 1'b1;
    cycle();
    br_valid = 1'b0;
    chk32("t5_br_addr", bus.imem_addr, 32'h5000);
    chk1("t5_br_valid", if_valid, 1'b0);
    chk1("t5_no_flush", flush_o, 1'b0);
    cycle();
    chk32("t5_if_pc", if_pc, 32'h5000);
    chk32("t5_if_instr", if_instr, mem_word(32'h5000));

    // Asynchronous reset while in KILL
    br_valid = 1'b1; br_target = 32'h6000; bus.imem_ack = 1'b0;
    cycle();
    br_valid = 1'b0;
    chk32("t6_kill_addr", bus.imem_addr, 32'h5004);
    #2 reset = 1'b0;
    #1;
    chk1("t6_async_req", bus.imem_req, 1'b0);
    chk1("t6_async_valid", if_valid, 1'b0);
    chk32("t6_async_if_pc", if_pc, 32'd0);
    chk32("t6_async_instr", if_instr, 32'd0);
    chk1("t6_async_flush", flush_o, 1'b0);
    chk32("t6_async_addr", bus.imem_addr, RESET_PC);
    @(negedge clk);
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    reset = 1'b1; bus.imem_ack = 1'b1;
    cycle();
    chk32("t6_restart0", bus.imem_addr, RESET_PC);
    cycle();
    chk32("t6_restart1", bus.imem_addr, RESET_PC + 32'd4);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      stall_i      = ($urandom_range(0, 9) < 3);
      bus.imem_ack = bus.imem_req && ($urandom_range(0, 9) < 6);
      br_valid     = ($urandom_range(0, 99) < 8);
      br_target    = pick_target();
      exc_req      = ($urandom_range(0, 99) < 2);
      eret_req     = ($urandom_range(0, 99) < 3);
      epc          = pick_target();
      cycle();
    end

    // Drain: with a free-flowing pipe and memory the stream must keep moving
    stall_i = 1'b0; br_valid = 1'b0; exc_req = 1'b0; eret_req = 1'b0;
    c0 = consumed;
    for (int n = 0; n < 12; n++) begin
      bus.imem_ack = bus.imem_req;
      cycle();
    end
    chk1("drain_progress", (consumed - c0) >= 6, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
